// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//
// Integer register file at the write-back end of the MEM/WB interface.
// Holds x1..x31 (x0 is hard-wired to zero and not stored), retires one
// write per cycle from MEM/WB, serves two combinational read ports to ID
// with same-cycle write-to-read bypass, and counts effective writes.
//
// Ports:
//   clk_in      rising-edge clock
//   rst_in      asynchronous active-low reset (clears array and counter)
//   rdy_in      global ready; 0 freezes all state and suppresses bypass
//   we_in       write enable (MEM/WB rdE)
//   wIdx_in     write index  (MEM/WB rdIdx)
//   wData_in    write data   (MEM/WB rdData)
//   re1_in      read port 1 enable
//   rIdx1_in    read port 1 index
//   rData1_out  read port 1 data, combinational
//   re2_in      read port 2 enable
//   rIdx2_in    read port 2 index
//   rData2_out  read port 2 data, combinational
//   wbCnt_out   registered count of effective writes since reset (wraps)
// ---------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              we_in,
    input  logic [IDX_W-1:0]  wIdx_in,
    input  logic [DATA_W-1:0] wData_in,
    input  logic              re1_in,
    input  logic [IDX_W-1:0]  rIdx1_in,
    output logic [DATA_W-1:0] rData1_out,
    input  logic              re2_in,
    input  logic [IDX_W-1:0]  rIdx2_in,
    output logic [DATA_W-1:0] rData2_out,
    output logic [CNT_W-1:0]  wbCnt_out
);

    localparam int NUM_REGS = 1 << IDX_W;

    // Entry 0 is deliberately absent: x0 is a constant, not storage.
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
    logic [CNT_W-1:0]  wb_cnt_q;
    logic [CNT_W-1:0]  wb_cnt_d;

    logic ew;         // architecturally effective write this cycle
    logic bypass_ok;  // write data may be forwarded to the read ports

    assign ew = we_in && rdy_in && (wIdx_in != '0);

    // While reset is held the array reads as zero and nothing is forwarded.
    assign bypass_ok = ew && rst_in;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any condition so
    // no path leaves it unassigned; that is what keeps latches from forming.
    always_comb begin
        regs_d   = regs_q;
        wb_cnt_d = wb_cnt_q;
        if (ew) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wIdx_in == IDX_W'(i)) begin
                    regs_d[i] = wData_in;
                end
            end
            wb_cnt_d = wb_cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: the array is reset because software observes x1..x31 as zero
    // straight out of reset; a reset-less memory would read as X. Sequential
    // state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_cnt_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wb_cnt_q <= wb_cnt_d;
        end
    end

    assign wbCnt_out = wb_cnt_q;

    // ---------------------------------------------------------------------
    // Read ports: array lookup (x0 falls through to zero), then bypass,
    // then the enable has final say.
    // ---------------------------------------------------------------------
    always_comb begin
        rData1_out = '0;
        rData2_out = '0;

        for (int i = 1; i < NUM_REGS; i++) begin
            if (rIdx1_in == IDX_W'(i)) begin
                rData1_out = regs_q[i];
            end
            if (rIdx2_in == IDX_W'(i)) begin
                rData2_out = regs_q[i];
            end
        end

        // ew already excludes index 0, so the bypass never exposes x0.
        if (bypass_ok && (wIdx_in == rIdx1_in)) begin
            rData1_out = wData_in;
        end
        if (bypass_ok && (wIdx_in == rIdx2_in)) begin
            rData2_out = wData_in;
        end

        if (!re1_in) begin
            rData1_out = '0;
        end
        if (!re2_in) begin
            rData2_out = '0;
        end
    end

endmodule
